// File: rtl/clk_div_bank_if.sv
// Ratio-programming bus of clk_div_bank: write strobe, channel select, ratio, per-channel ack.
interface clk_div_bank_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 8,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic              div_wr;
  logic [CH_W-1:0]   div_sel;
  logic [CNT_W-1:0]  div_val;
  logic [NUM_CH-1:0] div_ack;

  modport master (output div_wr, div_sel, div_val, input div_ack);
  modport slave  (input div_wr, div_sel, div_val, output div_ack);
endinterface

// File: rtl/clk_div_bank.sv
// Multi-channel glitch-free programmable clock divider with tick enables, run-time
// ratio updates applied at period boundaries, and a post-reset lock indicator.
module clk_div_bank #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 2,
  parameter int LOCK_CYCLES = 16,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              inclk0,
  input  logic              areset,
  clk_div_bank_if.slave     cfg,
  input  logic [NUM_CH-1:0] ch_en,
  output logic              c0,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic              locked
);
  localparam int LW = $clog2(LOCK_CYCLES + 1);

  assign c0 = inclk0;

  logic [CNT_W-1:0] val_clamped;
  assign val_clamped = (cfg.div_val < CNT_W'(2)) ? CNT_W'(2) : cfg.div_val;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] d_q, d_d, cnt_q, cnt_d, pval_q, pval_d;
    logic             pend_q, pend_d, clk_q, clk_d, tick_q, tick_d, ack_q, ack_d;
    logic             wr_hit, apply;
    logic [CNT_W:0]   half;

    // Out-of-range selects match no channel, so they are dropped without state change.
    assign wr_hit = cfg.div_wr && (cfg.div_sel == CH_W'(gi));
    assign half   = ({1'b0, d_q} + {{CNT_W{1'b0}}, 1'b1}) >> 1;

    always_comb begin
      d_d    = d_q;
      cnt_d  = cnt_q;
      pval_d = pval_q;
      pend_d = pend_q;
      clk_d  = 1'b0;
      tick_d = 1'b0;
      ack_d  = 1'b0;
      apply  = 1'b0;
      if (ch_en[gi]) begin
        if (cnt_q == d_q - 1'b1) begin
          apply  = pend_q;
          cnt_d  = '0;
          clk_d  = 1'b1;
          tick_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          clk_d = ({1'b0, cnt_d} < half);
        end
      end else begin
        apply = pend_q;
      end
      if (apply) begin
        d_d    = pval_q;
        pend_d = 1'b0;
        ack_d  = 1'b1;
      end
      // Parked at the last count so the first enabled edge starts a fresh period.
      if (!ch_en[gi]) cnt_d = d_d - 1'b1;
      if (wr_hit) begin
        pval_d = val_clamped;
        pend_d = 1'b1;
      end
    end

    always_ff @(posedge inclk0 or negedge areset) begin
      if (!areset) begin
        d_q    <= CNT_W'(DEFAULT_DIV);
        cnt_q  <= CNT_W'(DEFAULT_DIV - 1);
        pval_q <= CNT_W'(DEFAULT_DIV);
        pend_q <= 1'b0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
        ack_q  <= 1'b0;
      end else begin
        d_q    <= d_d;
        cnt_q  <= cnt_d;
        pval_q <= pval_d;
        pend_q <= pend_d;
        clk_q  <= clk_d;
        tick_q <= tick_d;
        ack_q  <= ack_d;
      end
    end

    assign clk_out[gi]     = clk_q;
    assign tick[gi]        = tick_q;
    assign cfg.div_ack[gi] = ack_q;
  end

  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic          locked_q, locked_d;

  always_comb begin
    lock_cnt_d = (lock_cnt_q == LW'(LOCK_CYCLES)) ? lock_cnt_q : lock_cnt_q + 1'b1;
    locked_d   = (lock_cnt_d == LW'(LOCK_CYCLES));
  end

  always_ff @(posedge inclk0 or negedge areset) begin
    if (!areset) begin
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  assign locked = locked_q;
endmodule

// File: tb/tb_clk_div_bank.sv
// Scoreboard bench for clk_div_bank: a waveform-queue reference model predicts each edge.
module tb_clk_div_bank;
  localparam int NCH   = 3;
  localparam int CW    = 8;
  localparam int CHW   = 2;
  localparam int DDIV  = 2;
  localparam int LOCKC = 16;

  logic           inclk0;
  logic           areset;
  logic [NCH-1:0] ch_en;
  logic           c0;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;
  logic           locked;

  clk_div_bank_if #(.NUM_CH(NCH), .CNT_W(CW)) cfg_if ();

  clk_div_bank #(
    .NUM_CH(NCH), .CNT_W(CW), .DEFAULT_DIV(DDIV), .LOCK_CYCLES(LOCKC)
  ) dut (
    .inclk0 (inclk0),
    .areset (areset),
    .cfg    (cfg_if),
    .ch_en  (ch_en),
    .c0     (c0),
    .clk_out(clk_out),
    .tick   (tick),
    .locked (locked)
  );

  initial inclk0 = 1'b0;
  always #5 inclk0 = ~inclk0;

  typedef struct packed {
    logic [NCH-1:0] clk;
    logic [NCH-1:0] tck;
    logic [NCH-1:0] ack;
    logic           lck;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // Reference model: each channel holds the remaining samples of its current period.
  int   d_m[NCH];
  int   pv_m[NCH];
  bit   pend_m[NCH];
  int   wave_q[NCH][$];
  int   lock_edges;
  logic [NCH-1:0] en_cur;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      d_m[c] = DDIV;
      pv_m[c] = DDIV;
      pend_m[c] = 1'b0;
      wave_q[c].delete();
    end
    lock_edges = 0;
  endtask

  task automatic step(input bit wr, input int sel, input int val, input logic [NCH-1:0] en);
    exp_t e;
    int   w;
    @(negedge inclk0);
    areset         = 1'b1;
    cfg_if.div_wr  = wr;
    cfg_if.div_sel = CHW'(sel);
    cfg_if.div_val = CW'(val);
    ch_en          = en;
    en_cur         = en;
    if (wr) $display("write sel=%0d val=%0d en=%b", sel, val, en);
    e = '0;
    for (int c = 0; c < NCH; c++) begin
      if (en[c]) begin
        if (wave_q[c].size() == 0) begin
          if (pend_m[c]) begin
            d_m[c] = pv_m[c];
            pend_m[c] = 1'b0;
            e.ack[c] = 1'b1;
          end
          for (int k = 0; k < d_m[c]; k++)
            wave_q[c].push_back(((k < (d_m[c] + 1) / 2) ? 1 : 0) + ((k == 0) ? 2 : 0));
        end
        w = wave_q[c].pop_front();
        e.clk[c] = (w & 1) != 0;
        e.tck[c] = (w & 2) != 0;
      end else begin
        wave_q[c].delete();
        if (pend_m[c]) begin
          d_m[c] = pv_m[c];
          pend_m[c] = 1'b0;
          e.ack[c] = 1'b1;
        end
      end
      if (wr && sel == c) begin
        pv_m[c] = (val < 2) ? 2 : val;
        pend_m[c] = 1'b1;
      end
    end
    if (lock_edges < LOCKC) lock_edges++;
    e.lck = (lock_edges >= LOCKC);
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0, 0, en_cur);
  endtask

  task automatic run_until(input int ch, input int sz, input int maxn);
    int n = 0;
    while (wave_q[ch].size() != sz && n < maxn) begin
      step(1'b0, 0, 0, en_cur);
      n++;
    end
    chk("phase_wait", 32'(wave_q[ch].size()), 32'(sz));
  endtask

  // Monitor: compares every registered output against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(posedge inclk0);
      #1;
      cyc++;
      chk("c0_high", 32'(c0), 32'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("clk_out", 32'(clk_out), 32'(e.clk));
        chk("tick", 32'(tick), 32'(e.tck));
        chk("div_ack", 32'(cfg_if.div_ack), 32'(e.ack));
        chk("locked", 32'(locked), 32'(e.lck));
        if (cfg_if.div_ack != '0) $display("ack cyc=%0d div_ack=%b", cyc, cfg_if.div_ack);
      end
    end
  end

  initial begin
    forever begin
      @(negedge inclk0);
      #1;
      chk("c0_low", 32'(c0), 32'd0);
    end
  end

  initial begin
    areset         = 1'b0;
    ch_en          = '1;
    en_cur         = '1;
    cfg_if.div_wr  = 1'b0;
    cfg_if.div_sel = '0;
    cfg_if.div_val = '0;
    model_reset();
    #12;
    chk("rst_clk_out", 32'(clk_out), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_ack", 32'(cfg_if.div_ack), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);

    idle(20);
    step(1'b1, 0, 5, en_cur);
    idle(12);
    step(1'b1, 1, 8, en_cur);
    run_until(1, 0, 20);
    step(1'b0, 0, 0, en_cur);
    step(1'b1, 1, 4, en_cur);
    step(1'b1, 1, 7, en_cur);
    idle(16);
    step(1'b1, 0, 1, en_cur);
    step(1'b1, 3, 9, en_cur);
    idle(10);

    step(1'b1, 0, 6, en_cur);
    run_until(0, 0, 40);
    step(1'b0, 0, 0, en_cur);
    run_until(0, 3, 10);
    step(1'b1, 0, 3, en_cur);
    run_until(0, 0, 10);
    step(1'b1, 0, 4, en_cur);
    idle(10);

    step(1'b1, 0, 6, en_cur);
    run_until(0, 0, 20);
    step(1'b0, 0, 0, en_cur);
    step(1'b0, 0, 0, en_cur & 3'b110);
    idle(4);
    step(1'b0, 0, 0, en_cur | 3'b001);
    idle(10);

    step(1'b1, 1, 9, en_cur);
    run_until(1, 0, 40);
    step(1'b0, 0, 0, en_cur);
    step(1'b1, 1, 5, en_cur);
    run_until(1, 4, 20);
    @(posedge inclk0);
    #3;
    areset = 1'b0;
    #1;
    chk("arst_clk_out", 32'(clk_out), 32'd0);
    chk("arst_tick", 32'(tick), 32'd0);
    chk("arst_ack", 32'(cfg_if.div_ack), 32'd0);
    chk("arst_locked", 32'(locked), 32'd0);
    model_reset();
    repeat (3) @(posedge inclk0);
    #1;
    chk("arst_hold_clk_out", 32'(clk_out), 32'd0);
    idle(20);

    for (int i = 0; i < 400; i++) begin
      logic [NCH-1:0] en;
      en = en_cur;
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 19) == 0) en[c] = ~en[c];
      if ($urandom_range(0, 3) == 0)
        step(1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 12)), en);
      else
        step(1'b0, 0, 0, en);
    end
    idle(4);
    repeat (2) @(posedge inclk0);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
Multi-channel programmable clock divider for the ping-pong datapath. It generates NUM_CH registered divided clocks from inclk0, plus matching single-cycle tick enables in the inclk0 domain. Divide ratios can be changed at run time; a new ratio takes effect only at a period boundary, so the outputs never glitch. c0 passes inclk0 through unchanged, and a locked flag tells downstream logic when the clocks are stable after reset.

Parameters:
NUM_CH, 2, number of divided-clock channels (>=1)
CNT_W, 8, width of divide ratio and per-channel counter
DEFAULT_DIV, 2, divide ratio loaded into every channel at reset (2..2^CNT_W-1)
LOCK_CYCLES, 16, inclk0 edges after reset release before locked asserts (>=1)
CH_W, max(1,clog2(NUM_CH)), derived, width of div_sel

Ports:
inclk0  input  1  source clock
areset  input  1  reset, asynchronous, active-low
div_wr  input  1  write strobe for a new divide ratio
div_sel  input  CH_W  target channel of div_wr
div_val  input  CNT_W  requested divide ratio
ch_en  input  NUM_CH  per-channel run enable
c0  output  1  equals inclk0 (combinational pass-through)
clk_out  output  NUM_CH  divided clocks, one flop per bit
tick  output  NUM_CH  1-cycle pulse coincident with each rising edge of clk_out
div_ack  output  NUM_CH  1-cycle pulse when a pending ratio is applied
locked  output  1  high once LOCK_CYCLES edges have elapsed since reset

Behaviour:
- Reset (async, areset=0), per channel:
  - D (active ratio) = DEFAULT_DIV; cnt = DEFAULT_DIV-1; pending flag = 0.
  - clk_out = 0, tick = 0, div_ack = 0, locked = 0; lock counter = 0.
  - Reset mid-operation forces these values immediately, independent of clock.
- Per channel, on each inclk0 rising edge while ch_en[i]=1:
  - H = ceil(D/2).
  - cnt_n = (cnt==D-1) ? 0 : cnt+1; cnt <= cnt_n.
  - clk_out[i] <= (cnt_n < H); tick[i] <= (cnt_n == 0).
  - Result: period = D inclk0 cycles; high for ceil(D/2) cycles, low for floor(D/2).
  - D=2 reproduces a plain toggle: 1,0,1,0... starting high on the first edge after reset.
- Ratio write:
  - On an edge with div_wr=1 and div_sel<NUM_CH: pending[div_sel] <= div_val, pend flag set.
  - div_val of 0 or 1 is clamped to 2.
  - div_sel>=NUM_CH is ignored: no state change, no ack.
- Ratio apply:
  - Enabled channel: applied on the edge where cnt==D-1 (period boundary) and pend=1. On that edge D <= pending, pend cleared, div_ack[i] <= 1 for one cycle. cnt wraps to 0, clk_out goes high, and the new period uses the new D and H from that edge.
  - Disabled channel: pending is applied on the next edge, with ack.
- Simultaneous events:
  - Second write before apply: overwrites pending (last wins); one ack only.
  - Write on the same edge as an apply to the same channel: the old pending value is applied and acked, and the new value becomes pending.
  - Writes to different channels are independent.
- Disable (ch_en[i]=0):
  - Next edge: clk_out[i] <= 0, tick[i] <= 0, cnt <= D-1.
  - A high phase is truncated at an edge, so there are no runt pulses shorter than one inclk0 cycle.
- Re-enable: the first enabled edge produces clk_out high and a tick (cnt wraps to 0).
- locked:
  - Lock counter saturates at LOCK_CYCLES; locked goes high on the LOCK_CYCLES-th edge after reset release.
  - Stays high until the next areset; unaffected by ch_en or ratio writes.
- Latency: ratio write to effect is at most D_old+1 edges (enabled channel). div_ack is coincident with the first high cycle of the new period.

Test Plan:
- Reset release, DEFAULT_DIV=2, ch_en=all 1 -> clk_out[0] = 1,0,1,0 from edge 1; tick high on edges 1,3,5; locked rises on edge 16, not 15.
- Write div_val=5 to ch0 mid-period -> current D=2 period completes; new period is 3 high / 2 low; div_ack[0] pulses exactly once, coincident with the first high cycle; ch1 unaffected.
- Write 4 then 7 to ch1 within one period -> only 7 applied, single ack; write div_val=1 -> D=2 behaviour; div_sel=NUM_CH -> no ack, no change.
- ch_en[0] dropped during a high phase with D=6 -> clk_out low on the next edge; re-enable -> high on the first enabled edge with tick; no pulse shorter than 1 cycle.
- Write to ch0 on the exact boundary edge where an older pending value is applied -> old value acked now, new value applied and acked at the following boundary.
- Assert areset mid-period with D=9 and pending set -> outputs go 0 asynchronously; after release D=DEFAULT_DIV, no ack, locked relocks after LOCK_CYCLES edges; c0 tracks inclk0 throughout.
